// File: rtl/ro_puf_pkg.sv
// Shared types and helpers for the ring-oscillator PUF comparator.
package ro_puf_pkg;

  // Measurement sequencer states
  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    COUNT,
    COMPARE,
    DONE
  } state_e;

  // Shortest settle period that still covers the 2-flop sync plus edge register
  localparam int SETTLE_MIN = 3;

  // Increment that sticks at the all-ones value of a counter 'width' bits wide
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
    logic [31:0] maxVal;
    maxVal = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (value >= maxVal) ? maxVal : value + 32'd1;
  endfunction

endpackage

// File: rtl/ro_puf_cmp_counter.sv
// Edge counter for one asynchronous RO: 2-flop synchroniser, rising-edge
// detect and a saturating counter with a sticky saturation flag.
module ro_edge_counter
  import ro_puf_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ro_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             sat_o
);

  logic             sync1_q, sync2_q, prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic             rise;

  assign rise = sync2_q & ~prev_q;

  // Next count: clear wins, otherwise count synchronised rising edges while enabled
  always_comb begin
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (clr_i) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (en_i && rise) begin
      cnt_d = CNT_W'(sat_inc(32'(cnt_q), CNT_W));
      if (cnt_d == '1) begin
        sat_d = 1'b1;
      end
    end
  end

  // Synchroniser, edge history and counter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      sync1_q <= ro_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

  assign cnt_o = cnt_q;
  assign sat_o = sat_q;

endmodule

// File: rtl/ro_puf_cmp.sv
// Ring-oscillator PUF comparator: enables a challenge-selected RO pair,
// counts their edges over a programmable window and compares the counts.
module ro_puf_cmp
  import ro_puf_pkg::*;
#(
  parameter int NUM_RO     = 16,
  parameter int SEL_W      = $clog2(NUM_RO),
  parameter int CNT_W      = 16,
  parameter int WIN_W      = 16,
  parameter int SETTLE_CYC = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [SEL_W-1:0]  sel1_i,
  input  logic [SEL_W-1:0]  sel2_i,
  input  logic [WIN_W-1:0]  win_len_i,
  input  logic [NUM_RO-1:0] ro_i,
  output logic [NUM_RO-1:0] ro_en_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              puf_bit_o,
  output logic [CNT_W-1:0]  cnt1_o,
  output logic [CNT_W-1:0]  cnt2_o,
  output logic              tie_o,
  output logic              sat_o,
  output logic              err_o
);

  localparam logic [WIN_W-1:0] SettleLast = WIN_W'(SETTLE_CYC - 1);

  state_e            state_q, state_d;
  logic [WIN_W-1:0]  cycCnt_q, cycCnt_d;
  logic [WIN_W-1:0]  winLen_q, winLen_d;
  logic [SEL_W-1:0]  sel1_q, sel1_d, sel2_q, sel2_d;
  logic              puf_q, puf_d, tie_q, tie_d, err_q, err_d;
  logic              challengeBad, clrCnt, cntEn;
  logic              roA, roB, satA, satB;
  logic [CNT_W-1:0]  cntA, cntB;
  logic [NUM_RO-1:0] enMask;

  assign challengeBad = (sel1_i == sel2_i) || (int'(sel1_i) >= NUM_RO) ||
                        (int'(sel2_i) >= NUM_RO) || (win_len_i == '0);
  assign roA    = ro_i[sel1_q];
  assign roB    = ro_i[sel2_q];
  assign cntEn  = (state_q == COUNT);
  assign enMask = (NUM_RO'(1) << sel1_q) | (NUM_RO'(1) << sel2_q);

  ro_edge_counter #(.CNT_W(CNT_W)) u_cntA (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .ro_i  (roA),
    .clr_i (clrCnt),
    .en_i  (cntEn),
    .cnt_o (cntA),
    .sat_o (satA)
  );

  ro_edge_counter #(.CNT_W(CNT_W)) u_cntB (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .ro_i  (roB),
    .clr_i (clrCnt),
    .en_i  (cntEn),
    .cnt_o (cntB),
    .sat_o (satB)
  );

  // Sequencer next state: accept/validate, settle, count window, compare, report
  always_comb begin
    state_d  = state_q;
    cycCnt_d = cycCnt_q;
    winLen_d = winLen_q;
    sel1_d   = sel1_q;
    sel2_d   = sel2_q;
    puf_d    = puf_q;
    tie_d    = tie_q;
    err_d    = err_q;
    clrCnt   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          sel1_d   = sel1_i;
          sel2_d   = sel2_i;
          winLen_d = win_len_i;
          cycCnt_d = '0;
          puf_d    = 1'b0;
          tie_d    = 1'b0;
          clrCnt   = 1'b1;
          err_d    = challengeBad;
          state_d  = challengeBad ? DONE : SETTLE;
        end
      end
      SETTLE: begin
        if (cycCnt_q == SettleLast) begin
          cycCnt_d = '0;
          state_d  = COUNT;
        end else begin
          cycCnt_d = cycCnt_q + 1'b1;
        end
      end
      COUNT: begin
        if (cycCnt_q == winLen_q - 1'b1) begin
          cycCnt_d = '0;
          state_d  = COMPARE;
        end else begin
          cycCnt_d = cycCnt_q + 1'b1;
        end
      end
      COMPARE: begin
        puf_d   = (cntA > cntB);
        tie_d   = (cntA == cntB);
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer and result registers; reset overrides any pending start
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cycCnt_q <= '0;
      winLen_q <= '0;
      sel1_q   <= '0;
      sel2_q   <= '0;
      puf_q    <= 1'b0;
      tie_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cycCnt_q <= cycCnt_d;
      winLen_q <= winLen_d;
      sel1_q   <= sel1_d;
      sel2_q   <= sel2_d;
      puf_q    <= puf_d;
      tie_q    <= tie_d;
      err_q    <= err_d;
    end
  end

  assign ro_en_o   = (state_q == SETTLE || state_q == COUNT) ? enMask : '0;
  assign busy_o    = (state_q != IDLE);
  assign done_o    = (state_q == DONE);
  assign puf_bit_o = puf_q;
  assign tie_o     = tie_q;
  assign err_o     = err_q;
  assign sat_o     = satA | satB;
  assign cnt1_o    = cntA;
  assign cnt2_o    = cntB;

endmodule

// File: tb/tb_ro_puf_cmp.sv
// Directed bench for ro_puf_cmp: two instances (16-bit and 4-bit counters)
// share all stimulus; ROs are modelled as free-running dividers of clk.
module tb_ro_puf_cmp;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  sel1, sel2;
  logic [15:0] winLen;
  logic [15:0] ro;

  logic [15:0] roEn, cnt1, cnt2;
  logic        busy, done, puf, tie, sat, err;
  logic [15:0] roEn4;
  logic [3:0]  cnt14, cnt24;
  logic        busy4, done4, puf4, tie4, sat4, err4;

  int halfPer[16] = '{default: 0};
  int phase[16]   = '{default: 0};
  bit clrReq[16]  = '{default: 1'b0};

  int testCount = 0;
  int failCount = 0;

  int          doneCyc, doneCnt, enBad;
  logic [15:0] enOr;
  logic        busyFirst;

  ro_puf_cmp dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .sel1_i(sel1), .sel2_i(sel2),
    .win_len_i(winLen), .ro_i(ro), .ro_en_o(roEn), .busy_o(busy), .done_o(done),
    .puf_bit_o(puf), .cnt1_o(cnt1), .cnt2_o(cnt2), .tie_o(tie), .sat_o(sat), .err_o(err)
  );

  ro_puf_cmp #(.CNT_W(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .sel1_i(sel1), .sel2_i(sel2),
    .win_len_i(winLen), .ro_i(ro), .ro_en_o(roEn4), .busy_o(busy4), .done_o(done4),
    .puf_bit_o(puf4), .cnt1_o(cnt14), .cnt2_o(cnt24), .tie_o(tie4), .sat_o(sat4), .err_o(err4)
  );

  always #5 clk = ~clk;

  // RO model: each active RO toggles every halfPer[i] clocks, off-edge
  initial begin
    ro = '0;
    forever begin
      @(posedge clk);
      #2;
      for (int i = 0; i < 16; i++) begin
        if (clrReq[i]) begin
          ro[i]     = 1'b0;
          phase[i]  = 0;
          clrReq[i] = 1'b0;
        end else if (halfPer[i] != 0) begin
          phase[i]++;
          if (phase[i] >= halfPer[i]) begin
            phase[i] = 0;
            ro[i]    = ~ro[i];
          end
        end
      end
    end
  end

  task automatic setRo(input int idx, input int half);
    halfPer[idx] = half;
    clrReq[idx]  = 1'b1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one start in cycle 0, then observe cycles 1..limit
  task automatic applyStimulus(input logic [3:0] s1, input logic [3:0] s2, input logic [15:0] w,
                               input int pulseAt, input int limit,
                               output int dCyc, output int dCnt, output logic [15:0] eOr,
                               output int eBad, output logic bFirst);
    logic [15:0] expMask;
    expMask = (16'd1 << s1) | (16'd1 << s2);
    dCyc = -1; dCnt = 0; eOr = '0; eBad = 0; bFirst = 1'b0;
    @(negedge clk);
    sel1 = s1; sel2 = s2; winLen = w; start = 1'b1;
    for (int cyc = 1; cyc <= limit; cyc++) begin
      @(negedge clk);
      start = (cyc == pulseAt);
      if (cyc == 1) bFirst = busy;
      if (done === 1'b1) begin
        dCnt++;
        if (dCyc < 0) dCyc = cyc;
      end
      eOr = eOr | roEn;
      if (roEn != '0 && roEn != expMask) eBad++;
    end
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sel1 = '0; sel2 = '0; winLen = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", 64'({roEn, busy, done, puf, cnt1, cnt2, tie, sat, err}), 64'd0);
    rst = 1'b0;
    setRo(3, 3); setRo(7, 4); setRo(1, 2);
    repeat (4) @(negedge clk);

    // A=RO3 (period 6), B=RO7 (period 8)
    applyStimulus(4'd3, 4'd7, 16'd240, 0, 250, doneCyc, doneCnt, enOr, enBad, busyFirst);
    checkOutput("t1_done_cycle", 64'(doneCyc), 64'd246);
    checkOutput("t1_done_count", 64'(doneCnt), 64'd1);
    checkOutput("t1_roen_or", 64'(enOr), 64'h0088);
    checkOutput("t1_roen_bad", 64'(enBad), 64'd0);
    checkOutput("t1_busy_cyc1", 64'(busyFirst), 64'd1);
    checkOutput("t1_cnt1_40", 64'(cnt1 >= 39 && cnt1 <= 41), 64'd1);
    checkOutput("t1_cnt2_30", 64'(cnt2 >= 29 && cnt2 <= 31), 64'd1);
    checkOutput("t1_status", 64'({puf, tie, sat, err, busy}), 64'b10000);

    // Swapped challenge inverts the response
    applyStimulus(4'd7, 4'd3, 16'd240, 0, 250, doneCyc, doneCnt, enOr, enBad, busyFirst);
    checkOutput("t2_done_cycle", 64'(doneCyc), 64'd246);
    checkOutput("t2_cnt1_30", 64'(cnt1 >= 29 && cnt1 <= 31), 64'd1);
    checkOutput("t2_cnt2_40", 64'(cnt2 >= 39 && cnt2 <= 41), 64'd1);
    checkOutput("t2_status", 64'({puf, tie, err}), 64'b000);

    // Identical selects are rejected
    applyStimulus(4'd5, 4'd5, 16'd240, 0, 6, doneCyc, doneCnt, enOr, enBad, busyFirst);
    checkOutput("t3_done_cycle", 64'(doneCyc), 64'd1);
    checkOutput("t3_roen_or", 64'(enOr), 64'd0);
    checkOutput("t3_result", 64'({err, puf, tie, cnt1, cnt2}), {61'd0, 3'b100} << 32);

    // Zero window is rejected
    applyStimulus(4'd3, 4'd7, 16'd0, 0, 6, doneCyc, doneCnt, enOr, enBad, busyFirst);
    checkOutput("t3b_done_cycle", 64'(doneCyc), 64'd1);
    checkOutput("t3b_roen_or", 64'(enOr), 64'd0);
    checkOutput("t3b_result", 64'({err, puf, tie, cnt1, cnt2}), {61'd0, 3'b100} << 32);

    // Saturation: RO1 period 4 over W=100 gives ~25 edges, RO0 silent
    applyStimulus(4'd1, 4'd0, 16'd100, 0, 110, doneCyc, doneCnt, enOr, enBad, busyFirst);
    checkOutput("t4_done_cycle", 64'(doneCyc), 64'd106);
    checkOutput("t4_cnt4_sat_value", 64'(cnt14), 64'd15);
    checkOutput("t4_sat4_flag", 64'({sat4, puf4, err4}), 64'b110);
    checkOutput("t4_wide_no_sat", 64'({sat, puf}), 64'b01);
    checkOutput("t4_wide_cnt1_25", 64'(cnt1 >= 24 && cnt1 <= 26), 64'd1);

    // Tie: RO2 and RO9 run in lockstep
    setRo(2, 3); setRo(9, 3);
    repeat (3) @(negedge clk);
    applyStimulus(4'd2, 4'd9, 16'd64, 0, 74, doneCyc, doneCnt, enOr, enBad, busyFirst);
    checkOutput("t5_done_cycle", 64'(doneCyc), 64'd70);
    checkOutput("t5_tie_puf", 64'({tie, puf, err}), 64'b100);
    checkOutput("t5_cnt1_range", 64'(cnt1 >= 9 && cnt1 <= 12), 64'd1);

    // Reset in COUNT cycle 50, with a start in the reset cycle that must be dropped
    @(negedge clk);
    sel1 = 4'd3; sel2 = 4'd7; winLen = 16'd240; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (S + 50 - 1) @(negedge clk);
    checkOutput("t6_counting", 64'({busy, roEn}), {47'd0, 1'b1, 16'h0088});
    checkOutput("t6_live_cnt", 64'(cnt1 >= 6 && cnt1 <= 10), 64'd1);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    checkOutput("t6_after_reset", 64'({roEn, busy, done, puf, cnt1, cnt2, tie, sat, err}), 64'd0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    checkOutput("t6_start_dropped", 64'(busy), 64'd0);

    // Normal run after reset, with an ignored start pulse mid-COUNT
    applyStimulus(4'd3, 4'd7, 16'd240, 100, 260, doneCyc, doneCnt, enOr, enBad, busyFirst);
    checkOutput("t7_done_cycle", 64'(doneCyc), 64'd246);
    checkOutput("t7_single_done", 64'(doneCnt), 64'd1);
    checkOutput("t7_idle_after", 64'(busy), 64'd0);
    checkOutput("t7_puf", 64'({puf, tie, err}), 64'b100);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/ro_puf_cmp.md
# ro_puf_cmp

Parametrised ring-oscillator PUF comparator that replaces the fixed 16-RO, 4-bit-select bit cell. It enables a challenge-selected pair of oscillators from an `NUM_RO`-wide bank, counts their rising edges over a programmable window, and produces one response bit. It also reports raw counts, tie, saturation and challenge-error status. It sits between the RO bank and the response-collection logic, and a start/done handshake drives each measurement.

## Interface
- `NUM_RO`, 16: oscillators in the bank; must be at least 2.
- `SEL_W`, `$clog2(NUM_RO)`: challenge select width.
- `CNT_W`, 16: edge-counter width.
- `WIN_W`, 16: window-length width.
- `SETTLE_CYC`, 4: cycles between enable and counting; must be at least 3.

- `clk_i`  in  1  system clock, the only clock.
- `rst_i`  in  1  synchronous, active-high reset.
- `start_i`  in  1  measurement request; accepted only in IDLE.
- `sel1_i`  in  SEL_W  index of RO A.
- `sel2_i`  in  SEL_W  index of RO B.
- `win_len_i`  in  WIN_W  count window in clk cycles.
- `ro_i`  in  NUM_RO  RO outputs, asynchronous, pre-divided so each is below clk/2.
- `ro_en_o`  out  NUM_RO  enables only the two selected ROs.
- `busy_o`  out  1  high in every state except IDLE.
- `done_o`  out  1  one-cycle pulse when results are valid.
- `puf_bit_o`  out  1  1 if count A > count B.
- `cnt1_o`  out  CNT_W  final edge count of RO A.
- `cnt2_o`  out  CNT_W  final edge count of RO B.
- `tie_o`  out  1  counts are equal.
- `sat_o`  out  1  either counter saturated.
- `err_o`  out  1  challenge rejected.

## Operation
- FSM states: IDLE, SETTLE, COUNT, COMPARE, DONE.
- IDLE with `start_i`=1:
  - `sel1_i`, `sel2_i` and `win_len_i` are latched.
  - The challenge is invalid if `sel1_i`==`sel2_i`, if either select is ≥`NUM_RO`, or if `win_len_i`==0.
  - Invalid: go to DONE with `err_o`=1, counts 0 and `ro_en_o`=0.
  - Valid: clear counters and status, then go to SETTLE.
- SETTLE:
  - `ro_en_o` has exactly bits sel1 and sel2 set.
  - Each selected RO passes through a 2-flop synchroniser and an edge-detect register; no counting takes place.
  - Lasts `SETTLE_CYC` cycles, then go to COUNT.
- COUNT:
  - A synchronised rising edge increments its counter in the same cycle.
  - Counters saturate at all-ones and set the sticky `sat_o`.
  - Lasts `win_len` cycles, then go to COMPARE.
- COMPARE:
  - `ro_en_o` drops to 0.
  - Register `puf_bit_o` = (cntA > cntB) and `tie_o` = (cntA == cntB). On a tie, `puf_bit_o`=0.
- DONE: `done_o`=1 for one cycle, then go to IDLE.
- Results and status hold until the next accepted start, which clears them.
- `start_i` is ignored while `busy_o`=1; no queuing.
- The A/B ordering is significant: swapping the selects inverts `puf_bit_o` unless the counts tie.

## Timing
- Start accepted at cycle 0, valid challenge:
  - SETTLE occupies cycles 1..S, where S = `SETTLE_CYC`.
  - COUNT occupies cycles S+1..S+W, where W = `win_len`.
  - COMPARE is cycle S+W+1.
  - `done_o` is high in cycle S+W+2.
- Invalid challenge: `done_o` is high in cycle 1.
- `busy_o` is high from cycle 1 through the DONE cycle inclusive.
- `start_i` may be reasserted in the cycle after DONE.
- Reset (any state, including mid-COUNT):
  - Next cycle the FSM is in IDLE.
  - All outputs are 0: `ro_en_o`, `busy_o`, `done_o`, `puf_bit_o`, `cnt1_o`, `cnt2_o`, `tie_o`, `sat_o`, `err_o`.
  - Synchronisers are cleared.
- Reset and `start_i` in the same cycle: reset wins and the start is dropped.
- An edge arriving in the last COUNT cycle is counted; one arriving in COMPARE is not.

## Structure
- Package `ro_puf_pkg` holds:
  - the FSM state enum;
  - `SETTLE_MIN`=3;
  - a `sat_inc` function implementing a saturating increment of width CNT_W.
- Sub-module `ro_edge_counter` (2-flop sync, edge detect, saturating counter, `clr`/`en` inputs) is instantiated twice.
- The select muxes from `ro_i` and the FSM live in the top level.

## Test plan
- RO3 toggles every 3 clk, RO7 every 4 clk; sel1=3, sel2=7, W=240 → `cnt1_o`=40±1, `cnt2_o`=30±1, `puf_bit_o`=1, `done_o` at cycle 246, `ro_en_o`=0x0088 during SETTLE and COUNT.
- Same stimulus with sel1=7, sel2=3 → `puf_bit_o`=0 and counts swapped.
- sel1=sel2=5 → `err_o`=1, `done_o` at cycle 1, `ro_en_o` never nonzero. Repeat with W=0 → same response.
- CNT_W=4, RO toggling every 2 clk, W=100 → count=15, `sat_o`=1.
- Two ROs with identical period, W=64 → `tie_o`=1, `puf_bit_o`=0.
- `rst_i` asserted at COUNT cycle 50 → next cycle IDLE with all outputs 0. A following start completes normally. A `start_i` pulse issued mid-COUNT is ignored: only one `done_o`.
